// File: rtl/i2s_dac_tx_if.sv
// rtl/i2s_dac_tx_if.sv - sample handshake between the sample-select mux and i2s_dac_tx
//
// Purpose: carries one mono sample per strobe from the upstream synth/sampler path
// into the I2S transmitter, and the consumption strobe back so upstream can pace itself.
//
// Signals:
//   sample_in     upstream -> tx   DATA_W-bit two's-complement sample
//   sample_valid  upstream -> tx   one-cycle strobe, loads sample_in into the holding register
//   data_over     tx -> upstream   one-cycle strobe, holding register copied into the frame
//
// Modports: master = upstream source, slave = transmitter.

interface i2s_dac_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              data_over;

  modport master (
    output sample_in,
    output sample_valid,
    input  data_over
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output data_over
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC serial transmitter, mono sample duplicated on both channels
//
// Purpose: double-buffers 16-bit mono samples arriving on the 50 MHz system clock and
// shifts the current frame out MSB-first in I2S format (one-bit delay after the word
// select edge) on both channels. Bit and word timing come from the codec-mastered
// AUD_BCLK / AUD_DACLRCK, which are synchronized and edge-detected inside this block.
//
// Ports:
//   Clk          in   system clock, all logic on its rising edge
//   Reset        in   synchronous, active-high
//   enable       in   high once the codec is initialised; low forces idle
//   smp          if   slave side of i2s_dac_tx_if (sample_in, sample_valid, data_over)
//   AUD_BCLK     in   codec bit clock, asynchronous to Clk
//   AUD_DACLRCK  in   codec word select, asynchronous to Clk; 0 = left, 1 = right
//   AUD_DACDAT   out  registered serial data to the codec
//   underrun     out  sticky: a left frame started with no new sample since the last one

module i2s_dac_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  i2s_dac_tx_if.slave smp,
  input  logic        AUD_BCLK,
  input  logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Synchronizers. LRCK uses the same depth as BCLK so that a word-select change
  // made at a BCLK falling edge is visible on exactly the cycle the fall is detected.
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_prev;
  logic                   bclk_cur;
  logic                   lrck_cur;
  logic                   fall;

  logic                   lr_last;
  logic [DATA_W-1:0]      hold;
  logic                   fresh;
  logic [DATA_W-1:0]      frame;
  logic [DATA_W-1:0]      shift;
  logic [CNT_W-1:0]       bitcnt;
  logic                   dacdat;
  logic                   data_over_q;

  logic                   lr_change;
  logic                   left_start;
  logic                   right_start;
  logic                   shift_step;
  logic [DATA_W-1:0]      next_frame;

  assign bclk_cur  = bclk_sync[SYNC_STAGES-1];
  assign lrck_cur  = lrck_sync[SYNC_STAGES-1];
  assign fall      = bclk_prev & ~bclk_cur;
  assign lr_change = fall && (lrck_cur != lr_last);

  // A sample strobed on the very cycle of a left start goes straight into the frame.
  assign next_frame = smp.sample_valid ? smp.sample_in : hold;

  assign AUD_DACDAT    = dacdat;
  assign smp.data_over = data_over_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_sync <= '0;
      lrck_sync <= '1;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_prev <= bclk_cur;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    left_start  = 1'b0;
    right_start = 1'b0;
    shift_step  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
        end
        S_ARMED: begin
          // Only a change to left may start output; right starts are ignored here.
          if (lr_change && !lrck_cur) begin
            state_d    = S_RUN;
            left_start = 1'b1;
          end
        end
        S_RUN: begin
          if (lr_change) begin
            left_start  = ~lrck_cur;
            right_start = lrck_cur;
          end else if (fall) begin
            shift_step = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      lr_last     <= 1'b1;
      hold        <= '0;
      fresh       <= 1'b0;
      frame       <= '0;
      shift       <= '0;
      bitcnt      <= CNT_W'(DATA_W);
      dacdat      <= 1'b0;
      data_over_q <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_over_q <= 1'b0;

      // Word select is tracked on every fall, in every state, so that arming
      // mid-left does not mistake the current channel for a fresh left start.
      if (fall) begin
        lr_last <= lrck_cur;
      end

      if (smp.sample_valid) begin
        hold  <= smp.sample_in;
        fresh <= 1'b1;
      end

      if (left_start) begin
        frame       <= next_frame;
        shift       <= next_frame;
        bitcnt      <= '0;
        dacdat      <= 1'b0;
        data_over_q <= 1'b1;
        if (!fresh && !smp.sample_valid) begin
          underrun <= 1'b1;
        end
        fresh <= 1'b0;
      end else if (right_start) begin
        shift  <= frame;
        bitcnt <= '0;
        dacdat <= 1'b0;
      end else if (shift_step) begin
        if (bitcnt < CNT_W'(DATA_W)) begin
          dacdat <= shift[DATA_W-1];
          shift  <= {shift[DATA_W-2:0], 1'b0};
          bitcnt <= bitcnt + CNT_W'(1);
        end else begin
          dacdat <= 1'b0;
        end
      end

      // Leaving for idle silences the pin on the same edge.
      if (state_d == S_IDLE) begin
        dacdat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - self-checking bench for i2s_dac_tx (SYNC_STAGES 2 and 3)

module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        bclk;
  logic        lrck;
  logic        dat2, dat3;
  logic        ur2, ur3;

  always #10 clk = ~clk;

  i2s_dac_tx_if #(.DATA_W(16)) sif2 ();
  i2s_dac_tx_if #(.DATA_W(16)) sif3 ();

  i2s_dac_tx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .Clk(clk), .Reset(rst), .enable(enable), .smp(sif2),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat2), .underrun(ur2)
  );

  i2s_dac_tx #(.DATA_W(16), .SYNC_STAGES(3)) dut3 (
    .Clk(clk), .Reset(rst), .enable(enable), .smp(sif3),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat3), .underrun(ur3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Codec: 16 Clk per BCLK, 64 BCLK per LRCK period; p is the phase applied next.
  int nidx = 0;
  int p = 0;
  bit codec_on = 0;

  // Reference model: slot-level behaviour of the I2S stream.
  logic [15:0] m_hold, m_frame;
  bit   m_fresh, m_ur, m_run, m_lr_last, m_active;
  int   m_k, m_do_idx;

  logic [15:0] cap_l, cap_r;
  int   do_cnt;
  logic obs_dat2, obs_dat3;

  typedef struct {
    bit          has;
    bit          two;
    logic [15:0] s_a;
    logic [15:0] s_b;
    int          off;
    logic [15:0] exp_word;
    bit          exp_ur;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = '0; m_frame = '0; m_fresh = 0; m_ur = 0; m_run = 0;
    m_lr_last = 1; m_active = 0; m_k = 99; m_do_idx = -10;
  endtask

  // One BCLK fall, as seen once the synchronizer has caught up with it.
  task automatic model_fall(input bit l);
    bit start;
    start = (l != m_lr_last);
    m_lr_last = l;
    if (start && enable && !l) begin
      m_frame  = m_hold;
      if (!m_fresh) m_ur = 1;
      m_fresh  = 0;
      m_run    = 1;
      m_active = 1;
      m_k      = 0;
      m_do_idx = nidx + 1;
    end else if (start && l && m_run) begin
      m_active = 1;
      m_k      = 0;
    end else if (m_k < 99) begin
      m_k++;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d);
    int   s;
    logic expb;
    @(negedge clk);
    nidx++;
    obs_dat2 = dat2;
    obs_dat3 = dat3;
    chk("data_over", sif2.data_over, 32'(nidx == m_do_idx));
    chk("data_over_s3", sif3.data_over, 32'(nidx == m_do_idx + 1));
    if (sif2.data_over) do_cnt++;
    if (codec_on && (p % 16) == 8) begin
      s    = p / 16;
      expb = (m_run && m_active && m_k >= 1 && m_k <= 16) ? m_frame[16 - m_k] : 1'b0;
      chk("dacdat", dat2, expb);
      chk("dacdat_s3", dat3, expb);
      chk("underrun", ur2, m_ur);
      chk("underrun_s3", ur3, m_ur);
      if (s >= 1 && s <= 16) cap_l[16 - s] = dat2;
      if (s >= 33 && s <= 48) cap_r[48 - s] = dat2;
    end
    if (codec_on) begin
      bclk = ((p % 16) >= 8);
      lrck = (p >= 512);
    end
    sif2.sample_valid = v; sif2.sample_in = d;
    sif3.sample_valid = v; sif3.sample_in = d;
    if (rst) begin
      model_reset();
    end else begin
      if (v) begin
        m_hold  = d;
        m_fresh = 1;
      end
      if (!enable) begin
        m_run    = 0;
        m_active = 0;
      end
      if (codec_on && (p % 16) == 2) model_fall((p - 2) >= 512);
    end
    if (codec_on) p = (p + 1) % 1024;
  endtask

  task automatic run_until(input int pt);
    int guard;
    guard = 0;
    while (p != pt && guard < 2048) begin
      step(0, 16'h0);
      guard++;
    end
    if (p != pt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until: phase %0d, required %0d", p, pt);
    end
  endtask

  // One LRCK period starting at phase 900; the left boundary is at index 124.
  task automatic run_unit(input bit has, input bit two, input logic [15:0] a,
                          input logic [15:0] b, input int off);
    cap_l  = '0;
    cap_r  = '0;
    do_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (has && i == 124 + off) step(1, b);
      else if (has && two && i == 124 + off - 30) step(1, a);
      else step(0, 16'h0);
    end
  endtask

  initial begin
    int lat2, lat3;
    bit has;
    logic [15:0] val;
    int off;

    tbl[0] = '{1, 0, 16'h0000, 16'hA5C3, -100, 16'hA5C3, 0};
    tbl[1] = '{1, 0, 16'h0000, 16'h8001, 2, 16'h8001, 0};
    tbl[2] = '{1, 1, 16'h1111, 16'h7FFE, -40, 16'h7FFE, 0};
    tbl[3] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h7FFE, 1};
    tbl[4] = '{1, 0, 16'h0000, 16'h0001, -120, 16'h0001, 1};
    tbl[5] = '{1, 1, 16'hFFFF, 16'h0000, -5, 16'h0000, 1};

    rst = 1; enable = 0; bclk = 1; lrck = 1;
    sif2.sample_valid = 0; sif2.sample_in = '0;
    sif3.sample_valid = 0; sif3.sample_in = '0;
    model_reset();
    cap_l = '0; cap_r = '0; do_cnt = 0;
    repeat (4) step(0, 16'h0);
    rst = 0;
    step(0, 16'h0);
    chk("reset_dacdat", dat2, 0);
    chk("reset_dacdat_s3", dat3, 0);
    chk("reset_underrun", ur2, 0);
    chk("reset_underrun_s3", ur3, 0);

    enable = 1;
    repeat (4) step(0, 16'h0);
    codec_on = 1;
    p = 896;
    run_until(900);

    for (int i = 0; i < 6; i++) begin
      run_unit(tbl[i].has, tbl[i].two, tbl[i].s_a, tbl[i].s_b, tbl[i].off);
      chk($sformatf("tbl%0d_left", i), cap_l, tbl[i].exp_word);
      chk($sformatf("tbl%0d_right", i), cap_r, tbl[i].exp_word);
      chk($sformatf("tbl%0d_underrun", i), ur2, tbl[i].exp_ur);
      chk($sformatf("tbl%0d_data_over_count", i), do_cnt, 1);
    end

    for (int i = 0; i < 12; i++) begin
      has = ($urandom_range(0, 3) != 0);
      val = 16'($urandom);
      off = int'($urandom_range(0, 122)) - 120;
      run_unit(has, 0, 16'h0, val, off);
      chk("rand_left", cap_l, m_frame);
      chk("rand_right", cap_r, m_frame);
      chk("rand_data_over_count", do_cnt, 1);
    end

    // Latency from the BCLK pin fall of slot 1 to the MSB appearing.
    run_until(1000);
    step(1, 16'hC0DE);
    run_until(16);
    chk("latency_pre", obs_dat2, 0);
    step(0, 16'h0);
    lat2 = 0; lat3 = 0;
    for (int e = 1; e <= 8; e++) begin
      step(0, 16'h0);
      if (lat2 == 0 && obs_dat2 === 1'b1) lat2 = e;
      if (lat3 == 0 && obs_dat3 === 1'b1) lat3 = e;
    end
    chk("latency_sync2", lat2, 3);
    chk("latency_sync3", lat3, 4);

    // Arming while the right channel is in progress.
    run_until(560);
    rst = 1; enable = 0;
    repeat (3) step(0, 16'h0);
    rst = 0;
    step(0, 16'h0);
    run_until(600);
    enable = 1;
    do_cnt = 0;
    run_until(700);
    step(1, 16'h5A3C);
    run_until(0);
    chk("arm_no_data_over", do_cnt, 0);
    cap_l = '0;
    run_until(280);
    chk("arm_first_left", cap_l, 16'h5A3C);
    chk("arm_data_over", do_cnt, 1);
    chk("arm_underrun", ur2, 0);

    // Reset after 7 bits of a left word.
    run_until(950);
    step(1, 16'hFFC0);
    run_until(122);
    chk("pre_reset_bit", obs_dat2, 1);
    rst = 1; enable = 0;
    step(0, 16'h0);
    step(0, 16'h0);
    chk("reset_mid_dacdat", obs_dat2, 0);
    chk("reset_mid_dacdat_s3", obs_dat3, 0);
    chk("reset_mid_underrun", ur2, 0);
    rst = 0;
    run_until(600);
    enable = 1;
    do_cnt = 0;
    run_until(700);
    step(1, 16'h0F0F);
    run_until(0);
    chk("reset_restart_wait", do_cnt, 0);
    cap_l = '0;
    run_until(280);
    chk("reset_restart_left", cap_l, 16'h0F0F);
    chk("reset_restart_underrun", ur2, 0);

    // Enable dropped after 7 bits of a left word.
    run_until(950);
    step(1, 16'hFFFF);
    run_until(122);
    chk("pre_disable_bit", obs_dat2, 1);
    enable = 0;
    step(0, 16'h0);
    step(0, 16'h0);
    chk("disable_dacdat", obs_dat2, 0);
    chk("disable_dacdat_s3", obs_dat3, 0);
    do_cnt = 0;
    repeat (1100) step(0, 16'h0);
    chk("disable_no_data_over", do_cnt, 0);
    chk("disable_underrun", ur2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
